// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multicycle next-PC controller. Owns the program counter, fetches one
//   instruction at a time over a req/ready handshake, precomputes the branch
//   target during DECODE and applies the control unit's branch/jump decision
//   in EXEC to load the next PC.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : a jump-register to a non-word-aligned address sets a sticky
//               fault, keeps pc and parks the FSM in HALT until rst.
//   undefined : fault is tied 0; the target is forced to a word boundary.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   imem_req        fetch request (high only in FETCH)
//   imem_addr       fetch address, always equal to pc
//   imem_ready      fetch accepted, imem_rdata valid this cycle
//   imem_rdata      instruction word from memory
//   instr           latched instruction
//   instr_valid     high while in EXEC
//   branch_target   registered pc+4+(sign-extended imm << 2)
//   resolve_valid   control unit decision present (honoured only in EXEC)
//   resolve_kind    00 seq, 01 cond branch, 10 jump, 11 jump-register
//   resolve_taken   branch outcome for kind 01
//   resolve_reg     rs value for kind 11
//   pc              current program counter
//   fault           sticky misaligned jump-register fault
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] branch_target,
   input  logic        resolve_valid,
   input  logic [1:0]  resolve_kind,
   input  logic        resolve_taken,
   input  logic [31:0] resolve_reg,
   output logic [31:0] pc,
   output logic        fault
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      HALT   = 3'd4
   } state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] pc_plus4_reg;
   logic [31:0] instr_reg;
   logic [31:0] branch_target_reg;
   logic        imem_req_reg;
   logic        instr_valid_reg;

   logic [31:0] branch_offset;
   logic [31:0] jump_target;
   logic [31:0] resolved_pc;
   logic        resolve_fault;

   // Word offset: sign-extend the 16-bit immediate and scale by 4.
   assign branch_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
   // Region-relative jump: top nibble comes from the sequential PC.
   assign jump_target   = {pc_plus4_reg[31:28], instr_reg[25:0], 2'b00};

   // Next PC selected by the control unit's resolution (used only in EXEC,
   // where pc_plus4_reg already holds pc+4).
   always_comb begin
      resolved_pc   = pc_plus4_reg;
      resolve_fault = 1'b0;
      unique case (resolve_kind)
         2'b00: resolved_pc = pc_plus4_reg;
         2'b01: resolved_pc = resolve_taken ? branch_target_reg : pc_plus4_reg;
         2'b10: resolved_pc = jump_target;
         2'b11: begin
            resolved_pc = {resolve_reg[31:2], 2'b00};
`ifdef PC_ALIGN_CHECK_EN
            resolve_fault = (resolve_reg[1:0] != 2'b00);
`endif
         end
         default: resolved_pc = pc_plus4_reg;
      endcase
   end

`ifdef PC_ALIGN_CHECK_EN
   logic fault_reg;
   assign fault = fault_reg;
`else
   // Low address bits are simply dropped when alignment checking is off.
   logic unused_align_bits;
   assign unused_align_bits = &{1'b0, resolve_reg[1:0], resolve_fault};
   assign fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         pc_reg            <= RESET_PC;
         pc_plus4_reg      <= 32'd0;
         instr_reg         <= 32'd0;
         branch_target_reg <= 32'd0;
         imem_req_reg      <= 1'b0;
         instr_valid_reg   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
         fault_reg         <= 1'b0;
`endif
      end else begin
         unique case (state_reg)
            IDLE: begin
               state_reg    <= FETCH;
               imem_req_reg <= 1'b1;
            end
            FETCH: begin
               // Address is pc_reg, which cannot change here, so it stays
               // stable for the whole stall.
               if (imem_ready) begin
                  instr_reg    <= imem_rdata;
                  imem_req_reg <= 1'b0;
                  state_reg    <= DECODE;
               end
            end
            DECODE: begin
               pc_plus4_reg      <= pc_reg + 32'd4;
               branch_target_reg <= pc_reg + 32'd4 + branch_offset;
               instr_valid_reg   <= 1'b1;
               state_reg         <= EXEC;
            end
            EXEC: begin
               if (resolve_valid) begin
                  instr_valid_reg <= 1'b0;
                  if (resolve_fault) begin
                     // pc keeps the faulting instruction's address.
`ifdef PC_ALIGN_CHECK_EN
                     fault_reg <= 1'b1;
`endif
                     state_reg <= HALT;
                  end else begin
                     pc_reg       <= resolved_pc;
                     imem_req_reg <= 1'b1;
                     state_reg    <= FETCH;
                  end
               end
            end
            HALT: begin
               state_reg <= HALT;
            end
            default: begin
               state_reg       <= IDLE;
               imem_req_reg    <= 1'b0;
               instr_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req      = imem_req_reg;
   assign imem_addr     = pc_reg;
   assign pc            = pc_reg;
   assign instr         = instr_reg;
   assign instr_valid   = instr_valid_reg;
   assign branch_target = branch_target_reg;

endmodule
